move_scheduler: RTL and testbench
=================================

Name: move_scheduler

Overview:
- Sequences all piece-movement commands for the falling-block game board datapath. It replaces free-running per-input tick generators with a single arbiter.
- Owns the gravity timer, the soft-drop timer and the left/right auto-repeat timers.
- Arbitrates the pending move requests and issues at most one command at a time to the board datapath over a valid/ready handshake, then waits for the datapath's response.
- A blocked gravity move triggers a LOCK command.

Parameters:
- CNT_W, 25, width of every timer counter
- GRAV_PERIOD, 20000000, gravity interval in clk cycles at level 0
- LEVEL_STEP, 1500000, cycles subtracted from the gravity interval per level
- SOFT_PERIOD, 3000000, interval while btn_down is held; also the floor on gravity interval
- DAS_DELAY, 8000000, hold time before left/right auto-repeat starts
- DAS_REPEAT, 2000000, auto-repeat interval after DAS_DELAY

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- enable  in  1  game running; 0 freezes timers and request capture
- btn_left  in  1  synchronized, debounced level
- btn_right  in  1  synchronized, debounced level
- btn_rot  in  1  synchronized, debounced level
- btn_down  in  1  synchronized, debounced level
- level  in  4  current speed level, 0..15
- cmd_valid  out  1  command offered to datapath
- cmd_code  out  3  1=LEFT 2=RIGHT 3=ROT 4=DOWN 5=LOCK; 0 when idle
- cmd_ready  in  1  datapath accepts command
- resp_valid  in  1  one-cycle completion pulse from datapath
- resp_blocked  in  1  qualifies resp_valid: move was illegal, board unchanged
- busy  out  1  high from issue until response
- lock_pulse  out  1  one-cycle pulse when the LOCK response returns

Behaviour:
- Reset (async, resetn=0):
  - All timers clear to 0 and all pending flags clear.
  - State goes to IDLE.
  - cmd_valid=0, cmd_code=0, busy=0, lock_pulse=0.
  - The button edge-detect registers load 0, so a button already held when resetn releases registers as a rising edge on the first enabled cycle.
- Gravity timer:
  - grav_int = max(GRAV_PERIOD − level×LEVEL_STEP, SOFT_PERIOD), computed in CNT_W bits with saturation, no wrap.
  - While btn_down=1 the interval is SOFT_PERIOD instead.
  - The counter increments each enabled cycle. When counter ≥ interval−1 it sets pend_down and clears to 0.
  - A change of level or btn_down takes effect on the next compare; the counter is not cleared.
- Rising edges:
  - A rising edge of btn_rot sets pend_rot.
  - A rising edge of btn_left or btn_right sets the matching pending flag and clears that button's DAS counter.
- Auto-repeat:
  - Auto-repeat runs only while exactly one of left/right is held.
  - After DAS_DELAY cycles held, set pend; thereafter set it every DAS_REPEAT cycles.
  - Releasing the button clears its DAS counter.
  - Both held: no repeat; edges still count.
- Pending flags are single bits; repeated events before service coalesce.
- FSM states: IDLE, ISSUE, WAIT_RESP, LOCK_ISSUE.
  - IDLE: if any flag is pending, latch the winner into cmd_code, clear that flag, and go to ISSUE on the next cycle. Fixed priority ROT > LEFT > RIGHT > DOWN.
  - ISSUE: cmd_valid=1 and cmd_code is held stable until cmd_ready. On cmd_valid&cmd_ready go to WAIT_RESP the next cycle, with cmd_valid=0.
  - WAIT_RESP: wait for resp_valid.
    - DOWN response with resp_blocked=1 → LOCK_ISSUE.
    - LOCK response → lock_pulse=1 for one cycle, clear gravity counter and pend_down → IDLE.
    - Any other response → IDLE.
  - LOCK_ISSUE: present LOCK exactly like ISSUE, then go to WAIT_RESP.
- Blocked LEFT/RIGHT/ROT responses are ignored, with no retry.
- Timers and flags keep running in every FSM state, so requests arriving while busy stay pending.
- busy=1 in ISSUE, WAIT_RESP and LOCK_ISSUE.
- Latency: the minimum from a pending flag to cmd_valid is 1 cycle, i.e. the flag is set in cycle N and cmd_valid rises in cycle N+1.
- Back-to-back: an IDLE cycle always separates two commands.
- enable=0:
  - Timers hold, new flags are not set, and no new command starts from IDLE.
  - A command already in flight completes normally.
- A resp_valid arriving in IDLE or ISSUE is ignored.
- Reset mid-handshake drops cmd_valid immediately; the datapath must tolerate this.

Decomposition:
- A shared package holds:
  - the cmd_code constants (CMD_NOP, CMD_LEFT, CMD_RIGHT, CMD_ROT, CMD_DOWN, CMD_LOCK);
  - the FSM state encoding;
  - the CNT_W default.
- One sub-module, repeat_timer: the per-button DAS counter with inputs held, rise and enable, and output fire. It is instantiated twice, for left and right.
- Gravity timing and arbitration stay in the top module.

Test Plan:
- Bench parameters: GRAV_PERIOD=20, LEVEL_STEP=2, SOFT_PERIOD=4, DAS_DELAY=8, DAS_REPEAT=3, cmd_ready tied 1, resp_valid 2 cycles after accept.
- Gravity: level=0, idle for 100 cycles → DOWN issued every 20 cycles. level=15 → interval floors at 4 cycles. btn_down held → 4-cycle interval.
- Priority: btn_rot, btn_left and a gravity tick all land in the same cycle → commands issue in the order ROT, LEFT, DOWN, one at a time, each after the previous response.
- Auto-repeat: hold btn_left for 20 cycles → LEFT flags set at the edge, then at cycle 8, 11, 14, 17. Hold both buttons → only the two edge commands.
- Lock: respond to DOWN with resp_blocked=1 → LOCK issued next. Its response → lock_pulse for 1 cycle and the gravity counter reads 0.
- Handshake stall: hold cmd_ready=0 for 10 cycles → cmd_valid and cmd_code stay stable. A rot edge arriving during the stall stays pending and issues after the response.
- Reset/enable: deassert resetn in WAIT_RESP → all outputs 0 asynchronously. With enable=0 for 50 cycles → no cmd_valid and the timers are frozen.

Source files
------------

// File: rtl/move_scheduler_pkg.sv
// Shared constants for the move scheduler: command codes, FSM encoding and
// the default timer counter width.
package move_scheduler_pkg;

    localparam int unsigned CNT_W_DEF = 25;

    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_LEFT  = 3'd1;
    localparam logic [2:0] CMD_RIGHT = 3'd2;
    localparam logic [2:0] CMD_ROT   = 3'd3;
    localparam logic [2:0] CMD_DOWN  = 3'd4;
    localparam logic [2:0] CMD_LOCK  = 3'd5;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_ISSUE      = 2'd1;
    localparam logic [1:0] ST_WAIT_RESP  = 2'd2;
    localparam logic [1:0] ST_LOCK_ISSUE = 2'd3;

endpackage

// File: rtl/repeat_timer.sv
// Per-button auto-repeat (DAS) counter: first fire after DAS_DELAY held
// cycles, then every DAS_REPEAT cycles while the button stays held.
module repeat_timer
    import move_scheduler_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned DAS_DELAY  = 8000000,
    parameter int unsigned DAS_REPEAT = 2000000
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    input  logic held,
    input  logic rise,
    output logic fire
);

    localparam logic [CNT_W-1:0] FIRE_AT = CNT_W'(DAS_DELAY - 1);
    // Reloading here instead of clearing puts the next fire DAS_REPEAT cycles out.
    localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(DAS_DELAY - DAS_REPEAT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        fire  = 1'b0;
        if (!held || rise) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q >= FIRE_AT) begin
                fire  = 1'b1;
                cnt_d = RELOAD;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/move_scheduler.sv
// Single arbiter for all piece moves: gravity/soft-drop timing, left/right
// auto-repeat, fixed-priority issue over valid/ready and LOCK on blocked DOWN.
module move_scheduler
    import move_scheduler_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned GRAV_PERIOD = 20000000,
    parameter int unsigned LEVEL_STEP  = 1500000,
    parameter int unsigned SOFT_PERIOD = 3000000,
    parameter int unsigned DAS_DELAY   = 8000000,
    parameter int unsigned DAS_REPEAT  = 2000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_rot,
    input  logic       btn_down,
    input  logic [3:0] level,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    input  logic       cmd_ready,
    input  logic       resp_valid,
    input  logic       resp_blocked,
    output logic       busy,
    output logic       lock_pulse
);

    localparam int unsigned WW = CNT_W + 4;
    localparam logic [WW-1:0]    GRAV_W = WW'(GRAV_PERIOD);
    localparam logic [WW-1:0]    SOFT_W = WW'(SOFT_PERIOD);
    localparam logic [WW-1:0]    STEP_W = WW'(LEVEL_STEP);
    localparam logic [CNT_W-1:0] SOFT_C = CNT_W'(SOFT_PERIOD);

    logic [WW-1:0]    lvl_sub, grav_diff;
    logic [CNT_W-1:0] grav_int, grav_q, grav_d;
    logic             grav_tick;
    logic [2:0]       btn_now, btn_prev_q, btn_prev_d, rise;
    logic             fire_left, fire_right;
    logic             pend_left_q, pend_right_q, pend_rot_q, pend_down_q;
    logic             pend_left_d, pend_right_d, pend_rot_d, pend_down_d;
    logic             clr_left, clr_right, clr_rot, clr_down, lock_clr;
    logic [1:0]       state_q, state_d;
    logic [2:0]       code_q, code_d;
    logic             lock_q, lock_d;

    // Interval math is done CNT_W+4 wide so level*step can never wrap.
    assign lvl_sub   = STEP_W * WW'(level);
    assign grav_diff = GRAV_W - lvl_sub;

    always_comb begin
        if (btn_down || (lvl_sub >= GRAV_W) || (grav_diff < SOFT_W)) grav_int = SOFT_C;
        else                                                        grav_int = grav_diff[CNT_W-1:0];
    end

    assign grav_tick = enable && (grav_q >= grav_int - CNT_W'(1));

    always_comb begin
        grav_d = grav_q;
        if (lock_clr)       grav_d = '0;
        else if (grav_tick) grav_d = '0;
        else if (enable)    grav_d = grav_q + CNT_W'(1);
    end

    assign btn_now    = {btn_rot, btn_right, btn_left};
    assign rise       = enable ? (btn_now & ~btn_prev_q) : 3'b000;
    assign btn_prev_d = enable ? btn_now : btn_prev_q;

    repeat_timer #(.CNT_W(CNT_W), .DAS_DELAY(DAS_DELAY), .DAS_REPEAT(DAS_REPEAT)) u_rep_left (
        .clk(clk), .resetn(resetn), .enable(enable),
        .held(btn_left & ~btn_right), .rise(rise[0]), .fire(fire_left)
    );

    repeat_timer #(.CNT_W(CNT_W), .DAS_DELAY(DAS_DELAY), .DAS_REPEAT(DAS_REPEAT)) u_rep_right (
        .clk(clk), .resetn(resetn), .enable(enable),
        .held(btn_right & ~btn_left), .rise(rise[1]), .fire(fire_right)
    );

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        lock_d    = 1'b0;
        lock_clr  = 1'b0;
        clr_left  = 1'b0;
        clr_right = 1'b0;
        clr_rot   = 1'b0;
        clr_down  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    if (pend_rot_q) begin
                        code_d = CMD_ROT;   clr_rot   = 1'b1; state_d = ST_ISSUE;
                    end else if (pend_left_q) begin
                        code_d = CMD_LEFT;  clr_left  = 1'b1; state_d = ST_ISSUE;
                    end else if (pend_right_q) begin
                        code_d = CMD_RIGHT; clr_right = 1'b1; state_d = ST_ISSUE;
                    end else if (pend_down_q) begin
                        code_d = CMD_DOWN;  clr_down  = 1'b1; state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE, ST_LOCK_ISSUE: begin
                if (cmd_ready) state_d = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                if (resp_valid) begin
                    if ((code_q == CMD_DOWN) && resp_blocked) begin
                        code_d  = CMD_LOCK;
                        state_d = ST_LOCK_ISSUE;
                    end else begin
                        if (code_q == CMD_LOCK) begin
                            lock_d   = 1'b1;
                            lock_clr = 1'b1;
                        end
                        code_d  = CMD_NOP;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                code_d  = CMD_NOP;
                state_d = ST_IDLE;
            end
        endcase
    end

    // A new event in the same cycle as service re-arms the flag.
    assign pend_rot_d   = (pend_rot_q   & ~clr_rot)   | rise[2];
    assign pend_left_d  = (pend_left_q  & ~clr_left)  | rise[0] | fire_left;
    assign pend_right_d = (pend_right_q & ~clr_right) | rise[1] | fire_right;
    assign pend_down_d  = lock_clr ? 1'b0 : ((pend_down_q & ~clr_down) | grav_tick);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grav_q       <= '0;
            btn_prev_q   <= '0;
            pend_left_q  <= 1'b0;
            pend_right_q <= 1'b0;
            pend_rot_q   <= 1'b0;
            pend_down_q  <= 1'b0;
            state_q      <= ST_IDLE;
            code_q       <= CMD_NOP;
            lock_q       <= 1'b0;
        end else begin
            grav_q       <= grav_d;
            btn_prev_q   <= btn_prev_d;
            pend_left_q  <= pend_left_d;
            pend_right_q <= pend_right_d;
            pend_rot_q   <= pend_rot_d;
            pend_down_q  <= pend_down_d;
            state_q      <= state_d;
            code_q       <= code_d;
            lock_q       <= lock_d;
        end
    end

    assign cmd_valid  = (state_q == ST_ISSUE) || (state_q == ST_LOCK_ISSUE);
    assign cmd_code   = code_q;
    assign busy       = (state_q != ST_IDLE);
    assign lock_pulse = lock_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Scoreboard bench for move_scheduler: expected commands are queued with the
// stimulus and popped as the DUT presents accepted commands.
module tb_move_scheduler;
    import move_scheduler_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       enable = 1'b1;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_rot = 1'b0, btn_down = 1'b0;
    logic [3:0] level = 4'd0;
    logic       cmd_ready = 1'b1, resp_valid = 1'b0, resp_blocked = 1'b0;
    logic       cmd_valid, busy, lock_pulse;
    logic [2:0] cmd_code;

    always #5 clk = ~clk;

    move_scheduler #(
        .CNT_W(25), .GRAV_PERIOD(20), .LEVEL_STEP(2), .SOFT_PERIOD(4),
        .DAS_DELAY(8), .DAS_REPEAT(3)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .btn_left(btn_left), .btn_right(btn_right), .btn_rot(btn_rot), .btn_down(btn_down),
        .level(level), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ready(cmd_ready),
        .resp_valid(resp_valid), .resp_blocked(resp_blocked), .busy(busy), .lock_pulse(lock_pulse)
    );

    int         n_chk = 0, n_err = 0;
    int         cyc = 0, t0 = 0;
    logic [2:0] exp_q[$];
    int         acc_q[$], fire_l[$], fire_r[$];
    int         lock_n = 0, lock_at = -1;
    bit         block_down = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (resetn) begin
            if (cmd_valid && cmd_ready) begin
                acc_q.push_back(cyc - t0);
                check_eq("busy_issue", busy, 1);
                if (exp_q.size() == 0) check_eq("spurious_cmd", cmd_code, CMD_NOP);
                else                   check_eq("cmd_order", cmd_code, exp_q.pop_front());
            end
            if (dut.u_rep_left.fire)  fire_l.push_back(cyc - t0);
            if (dut.u_rep_right.fire) fire_r.push_back(cyc - t0);
            if (lock_pulse) begin
                lock_n++;
                lock_at = cyc - t0;
                check_eq("grav_cleared", dut.grav_q, 0);
            end
        end
    end

    // Datapath responder: response sampled two clocks after accept
    initial begin
        logic [2:0] c;
        forever begin
            @(negedge clk);
            if (resetn && cmd_valid && cmd_ready) begin
                c = cmd_code;
                @(posedge clk); #1;
                @(posedge clk); #1;
                resp_valid   = 1'b1;
                resp_blocked = (c == CMD_DOWN) && block_down;
                @(posedge clk); #1;
                resp_valid   = 1'b0;
                resp_blocked = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 resetn = 1'b0;
        repeat (4) @(posedge clk);
        exp_q.delete(); acc_q.delete(); fire_l.delete(); fire_r.delete();
        lock_n = 0; lock_at = -1;
        #1 resetn = 1'b1;
        t0 = cyc;
    endtask

    task automatic at_region(input int k);
        while (cyc - t0 < k) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin @(posedge clk); #2; n++; end
        check_eq(tag, exp_q.size(), 0);
    endtask

    task automatic check_times(input string tag, input int exp_t[$]);
        check_eq({tag, "_count"}, acc_q.size(), exp_t.size());
        for (int i = 0; i < exp_t.size() && i < acc_q.size(); i++)
            check_eq({tag, "_time"}, acc_q[i], exp_t[i]);
    endtask

    initial begin
        #1 resetn = 1'b0;
        #11;
        check_eq("rst_valid", cmd_valid, 0);
        check_eq("rst_code", cmd_code, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_lock", lock_pulse, 0);

        // Gravity at level 0: DOWN every 20 cycles
        level = 4'd0; do_reset();
        repeat (5) exp_q.push_back(CMD_DOWN);
        drain("grav0_drain", 150);
        check_times("grav0", '{21, 41, 61, 81, 101});

        // Level 15 floors at SOFT_PERIOD; btn_down forces it
        for (int m = 0; m < 2; m++) begin
            level = (m == 0) ? 4'd15 : 4'd0;
            btn_down = (m == 1);
            do_reset();
            repeat (4) exp_q.push_back(CMD_DOWN);
            drain("fast_drain", 60);
            check_times(m == 0 ? "lvl15" : "softdrop", '{5, 9, 13, 17});
        end
        btn_down = 1'b0; level = 4'd0;

        // ROT, LEFT and a gravity tick land together
        do_reset();
        at_region(19); btn_rot = 1'b1; btn_left = 1'b1;
        at_region(20); btn_rot = 1'b0; btn_left = 1'b0;
        exp_q.push_back(CMD_ROT); exp_q.push_back(CMD_LEFT); exp_q.push_back(CMD_DOWN);
        drain("prio_drain", 40);
        check_times("prio", '{21, 25, 29});

        // Left held 20 cycles from reset release: edge plus repeats at 8,11,14,17
        btn_left = 1'b1; do_reset();
        repeat (5) exp_q.push_back(CMD_LEFT);
        exp_q.push_back(CMD_DOWN);
        at_region(20); btn_left = 1'b0;
        drain("das_drain", 40);
        check_eq("das_fires", fire_l.size(), 4);
        for (int i = 0; i < fire_l.size() && i < 4; i++) check_eq("das_fire_at", fire_l[i], 8 + 3 * i);
        check_times("das", '{2, 10, 14, 18, 22, 26});

        // Both held: only the two edge commands
        btn_left = 1'b1; btn_right = 1'b1; do_reset();
        exp_q.push_back(CMD_LEFT); exp_q.push_back(CMD_RIGHT); exp_q.push_back(CMD_DOWN);
        at_region(20); btn_left = 1'b0; btn_right = 1'b0;
        drain("both_drain", 40);
        check_eq("both_fire_l", fire_l.size(), 0);
        check_eq("both_fire_r", fire_r.size(), 0);
        check_times("both", '{2, 6, 21});

        // Blocked DOWN -> LOCK, lock pulse, gravity restarts from 0
        block_down = 1'b1; do_reset();
        exp_q.push_back(CMD_DOWN); exp_q.push_back(CMD_LOCK);
        drain("lock_drain", 40);
        block_down = 1'b0;
        exp_q.push_back(CMD_DOWN);
        drain("lock_next_drain", 40);
        check_eq("lock_pulses", lock_n, 1);
        check_eq("lock_at", lock_at, 27);
        check_times("lock", '{21, 24, 48});

        // Handshake stall with a rot edge arriving mid-stall
        btn_rot = 1'b1; cmd_ready = 1'b0; do_reset();
        exp_q.push_back(CMD_ROT); exp_q.push_back(CMD_ROT); exp_q.push_back(CMD_DOWN);
        for (int k = 2; k < 12; k++) begin
            at_region(k);
            if (k == 3) btn_rot = 1'b0;
            if (k == 5) btn_rot = 1'b1;
            if (k == 7) btn_rot = 1'b0;
            @(negedge clk);
            check_eq("stall_valid", cmd_valid, 1);
            check_eq("stall_code", cmd_code, CMD_ROT);
        end
        at_region(12); cmd_ready = 1'b1;
        drain("stall_drain", 40);
        check_times("stall", '{12, 16, 21});

        // Reset while waiting for the response
        btn_rot = 1'b1; do_reset();
        exp_q.push_back(CMD_ROT);
        at_region(3); btn_rot = 1'b0;
        #2 check_eq("wait_busy", busy, 1);
        resetn = 1'b0;
        #1;
        check_eq("async_valid", cmd_valid, 0);
        check_eq("async_code", cmd_code, 0);
        check_eq("async_busy", busy, 0);
        check_eq("async_lock", lock_pulse, 0);
        check_eq("async_drain", exp_q.size(), 0);

        // enable=0 for 50 cycles freezes everything
        enable = 1'b0; do_reset();
        at_region(50);
        check_eq("dis_grav", dut.grav_q, 0);
        check_eq("dis_cmds", acc_q.size(), 0);
        check_eq("dis_busy", busy, 0);
        enable = 1'b1;
        exp_q.push_back(CMD_DOWN);
        drain("en_drain", 40);
        check_times("en", '{71});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
